uart_tx_arb: RTL and testbench

//   Round-robin arbiter sharing one uart_tx byte transmitter among N client requesters.

---
 rtl/uart_tx_arb_if.sv | 23 ++
 rtl/uart_tx_arb.sv | 132 +++++++++++++
 tb/tb_uart_tx_arb.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// Client-side and uart_tx-side handshake bundle for uart_tx_arb.
// master = arbiter, slave = clients plus the uart_tx instance.
interface uart_tx_arb_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]   cli_valid;
  logic [8*N-1:0] cli_data;
  logic [N-1:0]   cli_ready;
  logic [N-1:0]   cli_done;
  logic           utx_req;
  logic [7:0]     utx_data;
  logic           utx_ack;

  modport master (
    input  cli_valid, cli_data, utx_ack,
    output cli_ready, cli_done, utx_req, utx_data
  );

  modport slave (
    output cli_valid, cli_data, utx_ack,
    input  cli_ready, cli_done, utx_req, utx_data
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one toggle-handshake uart_tx among N byte clients.
// One byte per grant; completion reported to the owner once uart_tx acks.
module uart_tx_arb #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  uart_tx_arb_if.master        bus,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [IW-1:0] gnt, gnt_nxt;
  logic [IW-1:0] gsel, idx;
  logic          found;
  logic [7:0]    sel_byte;
  logic [N-1:0]  ready_q, ready_nxt;
  logic [N-1:0]  done_q, done_nxt;
  logic          req_q, req_nxt;
  logic [7:0]    data_q, data_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          busy_nxt;
  logic          err_set;

  // Round-robin pick: first pending client after the last completed owner
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = '0;
    for (int k = 1; k <= int'(N); k++) begin
      idx = IW'((int'(last) + k) % int'(N));
      if (!found && bus.cli_valid[idx]) begin
        found = 1'b1;
        gsel  = idx;
      end
    end
  end

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gsel == IW'(i)) sel_byte = bus.cli_data[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    gnt_nxt   = gnt;
    ready_nxt = '0;
    done_nxt  = '0;
    req_nxt   = req_q;
    data_nxt  = data_q;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          data_nxt  = sel_byte;
          ready_nxt = N'(1) << gsel;
          gnt_nxt   = gsel;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_nxt   = ~req_q;
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.utx_ack == req_q) begin
          state_nxt = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt != CW'(TIMEOUT))) begin
          // err fires once, on the cycle the counter lands on TIMEOUT
          cnt_nxt = cnt + CW'(1);
          err_set = (cnt == CW'(TIMEOUT - 1));
        end
      end
      S_DONE: begin
        done_nxt  = N'(1) << gnt;
        last_nxt  = gnt;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      last    <= IW'(N - 1);
      gnt     <= '0;
      ready_q <= '0;
      done_q  <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else if (enable) begin
      state   <= state_nxt;
      last    <= last_nxt;
      gnt     <= gnt_nxt;
      ready_q <= ready_nxt;
      done_q  <= done_nxt;
      req_q   <= req_nxt;
      data_q  <= data_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  assign bus.cli_ready = ready_q;
  assign bus.cli_done  = done_q;
  assign bus.utx_req   = req_q;
  assign bus.utx_data  = data_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: client BFMs, a toggle-ack uart_tx model,
// and a monitor that pops expected grants, bytes and completions.
module tb_uart_tx_arb;
  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 50;

  logic clk     = 1'b0;
  logic rstn    = 1'b1;
  logic enable  = 1'b0;
  logic err_clr = 1'b0;
  logic busy;
  logic err;

  uart_tx_arb_if #(.N(N)) bus ();

  uart_tx_arb #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .enable  (enable),
    .bus     (bus),
    .busy    (busy),
    .err     (err),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cl;
    logic [7:0] b;
  } gnt_t;

  int n_vec = 0;
  int n_bad = 0;

  gnt_t       exp_gnt[$];
  logic [7:0] exp_tx[$];
  int         exp_done[$];

  logic [7:0] cbuf[N][8];
  int         chead[N];
  int         ctail[N];

  logic       upd = 1'b0;
  logic       ack_hold = 1'b0;
  int         ack_delay = 3;
  logic       pending = 1'b0;
  int         pend_cnt = 0;
  logic [7:0] pend_byte = '0;

  always @(posedge clk) upd <= enable && rstn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_req(input int cl, input logic [7:0] b);
    cbuf[cl][ctail[cl] % 8] = b;
    ctail[cl]++;
  endtask

  task automatic expect_xfer(input int cl, input logic [7:0] b, input bit with_done);
    gnt_t g;
    g.cl = 4'(cl);
    g.b  = b;
    exp_gnt.push_back(g);
    exp_tx.push_back(b);
    if (with_done) exp_done.push_back(cl);
  endtask

  function automatic bit idle();
    bit r;
    r = !busy && !pending && exp_gnt.size() == 0 && exp_tx.size() == 0 && exp_done.size() == 0;
    for (int i = 0; i < int'(N); i++) if (chead[i] != ctail[i]) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    do begin
      step(1);
      k++;
    end while (!idle() && k < budget);
    if (!idle()) fail({name, " idle timeout"});
  endtask

  task automatic wait_pending(input int budget, input string name);
    int k;
    k = 0;
    do begin
      step(1);
      k++;
    end while (!pending && k < budget);
    if (!pending) fail({name, " request timeout"});
  endtask

  task automatic clear_clients();
    for (int i = 0; i < int'(N); i++) begin
      chead[i] = 0;
      ctail[i] = 0;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    ack_hold = 1'b0;
    pending = 1'b0;
    bus.utx_ack = 1'b0;
    clear_clients();
    step(3);
    rstn = 1'b1;
    step(1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " utx_req"},   32'(bus.utx_req),   32'(0));
    check({tag, " utx_data"},  32'(bus.utx_data),  32'(0));
    check({tag, " busy"},      32'(busy),          32'(0));
    check({tag, " err"},       32'(err),           32'(0));
    check({tag, " cli_ready"}, 32'(bus.cli_ready), 32'(0));
    check({tag, " cli_done"},  32'(bus.cli_done),  32'(0));
  endtask

  // Monitor, uart_tx model and client drivers share one negedge loop
  initial begin
    gnt_t e;
    bus.cli_valid = '0;
    bus.cli_data  = '0;
    bus.utx_ack   = 1'b0;
    forever begin
      @(negedge clk);
      if (upd && rstn) begin
        if (bus.cli_ready != '0) begin
          if (exp_gnt.size() == 0) fail("unexpected cli_ready");
          else begin
            e = exp_gnt.pop_front();
            check("cli_ready onehot", 32'(bus.cli_ready), 32'(1) << e.cl);
            check("utx_data at grant", 32'(bus.utx_data), 32'(e.b));
          end
          for (int i = 0; i < int'(N); i++)
            if (bus.cli_ready[i] && chead[i] != ctail[i]) chead[i]++;
        end
        if (bus.cli_done != '0) begin
          if (exp_done.size() == 0) fail("unexpected cli_done");
          else check("cli_done onehot", 32'(bus.cli_done), 32'(1) << exp_done.pop_front());
        end
      end
      if (rstn && bus.utx_req != bus.utx_ack) begin
        if (!pending) begin
          pending   = 1'b1;
          pend_cnt  = 0;
          pend_byte = bus.utx_data;
          if (exp_tx.size() == 0) fail("unexpected utx_req toggle");
          else check("tx byte", 32'(bus.utx_data), 32'(exp_tx.pop_front()));
        end else begin
          pend_cnt++;
        end
        if (!ack_hold && pend_cnt >= ack_delay) begin
          check("utx_data held until ack", 32'(bus.utx_data), 32'(pend_byte));
          bus.utx_ack = bus.utx_req;
          pending = 1'b0;
        end
      end
      for (int i = 0; i < int'(N); i++) begin
        if (chead[i] != ctail[i]) begin
          bus.cli_valid[i]        = 1'b1;
          bus.cli_data[8*i +: 8]  = cbuf[i][chead[i] % 8];
        end else begin
          bus.cli_valid[i]        = 1'b0;
          bus.cli_data[8*i +: 8]  = 8'h00;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       snap_req;
    logic [7:0] snap_data;
    int         chg;
    clear_clients();
    #1 rstn = 1'b0;
    enable = 1'b1;
    step(3);
    check_zero_outputs("reset");
    rstn = 1'b1;
    step(1);

    // single client byte
    expect_xfer(0, 8'hA5, 1'b1);
    push_req(0, 8'hA5);
    wait_idle(200, "t1");
    check("t1 utx_req toggled", 32'(bus.utx_req), 32'(1));

    // all four pending: strict rotation from client 0
    do_reset();
    expect_xfer(0, 8'h10, 1'b1);
    expect_xfer(1, 8'h11, 1'b1);
    expect_xfer(2, 8'h12, 1'b1);
    expect_xfer(3, 8'h13, 1'b1);
    expect_xfer(0, 8'h10, 1'b1);
    push_req(0, 8'h10); push_req(0, 8'h10);
    push_req(1, 8'h11); push_req(2, 8'h12); push_req(3, 8'h13);
    wait_idle(400, "t2");

    // streaming client 2 must yield to client 1
    do_reset();
    expect_xfer(2, 8'h20, 1'b1);
    push_req(2, 8'h20); push_req(2, 8'h21); push_req(2, 8'h22);
    chg = 0;
    while (exp_gnt.size() != 0 && chg < 50) begin
      step(1);
      chg++;
    end
    if (exp_gnt.size() != 0) fail("t3 first grant timeout");
    expect_xfer(1, 8'h31, 1'b1);
    expect_xfer(2, 8'h21, 1'b1);
    expect_xfer(2, 8'h22, 1'b1);
    push_req(1, 8'h31);
    wait_idle(400, "t3");

    // freeze with enable low mid-wait; ack lands during the freeze
    ack_delay = 5;
    expect_xfer(1, 8'h4B, 1'b1);
    push_req(1, 8'h4B);
    wait_pending(50, "t4");
    step(2);
    enable = 1'b0;
    snap_req  = bus.utx_req;
    snap_data = bus.utx_data;
    chg = 0;
    repeat (20) begin
      step(1);
      if (bus.utx_req != snap_req || bus.utx_data != snap_data || !busy || bus.cli_done != '0) chg++;
    end
    check("t4 frozen cycles changed", 32'(chg), 32'(0));
    check("t4 busy frozen", 32'(busy), 32'(1));
    enable = 1'b1;
    wait_idle(100, "t4");
    ack_delay = 3;

    // async reset during wait abandons the byte
    ack_hold = 1'b1;
    expect_xfer(0, 8'h5A, 1'b0);
    push_req(0, 8'h5A);
    wait_pending(50, "t5");
    step(3);
    rstn = 1'b0;
    #1;
    check_zero_outputs("t5 async reset");
    pending = 1'b0;
    ack_hold = 1'b0;
    bus.utx_ack = 1'b0;
    clear_clients();
    step(2);
    rstn = 1'b1;
    step(1);
    expect_xfer(3, 8'hC3, 1'b1);
    push_req(3, 8'hC3);
    wait_idle(200, "t5");

    // timeout: err after exactly TIMEOUT waiting cycles, clear, then set again
    ack_hold = 1'b1;
    expect_xfer(0, 8'h66, 1'b1);
    push_req(0, 8'h66);
    wait_pending(50, "t6");
    step(49);
    check("t6 err before timeout", 32'(err), 32'(0));
    step(1);
    check("t6 err at timeout", 32'(err), 32'(1));
    check("t6 busy in timeout", 32'(busy), 32'(1));
    step(5);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t6 err cleared", 32'(err), 32'(0));
    step(10);
    check("t6 err stays cleared", 32'(err), 32'(0));
    ack_hold = 1'b0;
    wait_idle(100, "t6a");

    ack_hold = 1'b1;
    expect_xfer(1, 8'h77, 1'b1);
    push_req(1, 8'h77);
    wait_pending(50, "t6b");
    step(49);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t6 set beats clear", 32'(err), 32'(1));
    step(2);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t6 err cleared again", 32'(err), 32'(0));
    ack_hold = 1'b0;
    wait_idle(100, "t6b");
    check("end busy", 32'(busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
